emergency_preempt_ctrl: RTL and testbench

Upstream stage of the intersection traffic/pedestrian controller. It produces that controller's `emergency` input from a raw, asynchronous and bouncy siren detector plus a synchronous manual override. The raw input is synchronised and qualified. Once active, emergency is held for a minimum time, then released through an all-red clearance interval. A saturating counter records how many preemption events have occurred.

---
 rtl/emergency_preempt_ctrl.sv | 109 ++++++++++
 tb/tb_emergency_preempt_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emergency_preempt_ctrl.sv
// Emergency preemption front end: synchronises and qualifies a bouncy siren input,
// merges a manual override, enforces a minimum hold and an all-red clearance, and counts events.
module emergency_preempt_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int QUAL_CYCLES  = 8,
  parameter int MIN_HOLD     = 32,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             siren_raw,
  input  logic             manual_override,
  input  logic             cfg_enable,
  output logic             emergency,
  output logic             all_red,
  output logic             busy,
  output logic [CNT_W-1:0] event_count
);

  localparam int MAX_A = (QUAL_CYCLES > MIN_HOLD) ? QUAL_CYCLES : MIN_HOLD;
  localparam int MAX_V = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
  localparam int CW    = (MAX_V > 2) ? $clog2(MAX_V) : 1;

  localparam logic [CW-1:0] Q_LAST = CW'(QUAL_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, QUALIFY, ACTIVE, CLEAR} state_t;

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic [CW-1:0]            r_qcnt;
  logic [CW-1:0]            r_hcnt;
  logic [CW-1:0]            r_ccnt;
  logic [CNT_W-1:0]         r_event_count;

  logic w_siren_s;
  logic w_req;

  assign w_siren_s = r_sync[SYNC_STAGES-1];
  assign w_req     = w_siren_s | manual_override;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_sync        <= '0;
      r_qcnt        <= '0;
      r_hcnt        <= '0;
      r_ccnt        <= '0;
      r_event_count <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], siren_raw};
      case (r_state)
        IDLE: begin
          if (cfg_enable && manual_override) begin
            r_state       <= ACTIVE;
            r_hcnt        <= '0;
            r_event_count <= sat_inc(r_event_count);
          end else if (cfg_enable && w_siren_s) begin
            r_state <= QUALIFY;
            r_qcnt  <= CW'(1);
          end
        end
        QUALIFY: begin
          // Losing enable aborts qualification even against a manual request.
          if (!cfg_enable || (!manual_override && !w_siren_s)) begin
            r_state <= IDLE;
            r_qcnt  <= '0;
          end else if (manual_override || r_qcnt == Q_LAST) begin
            r_state       <= ACTIVE;
            r_qcnt        <= '0;
            r_hcnt        <= '0;
            r_event_count <= sat_inc(r_event_count);
          end else begin
            r_qcnt <= r_qcnt + 1'b1;
          end
        end
        ACTIVE: begin
          if (r_hcnt != H_LAST) begin
            r_hcnt <= r_hcnt + 1'b1;
          end else if (!w_req) begin
            r_state <= CLEAR;
            r_ccnt  <= '0;
          end
        end
        CLEAR: begin
          if (r_ccnt == C_LAST) begin
            r_state <= IDLE;
          end else begin
            r_ccnt <= r_ccnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state so no input reaches them combinationally.
  assign emergency   = (r_state == ACTIVE);
  assign all_red     = (r_state == CLEAR);
  assign busy        = (r_state != IDLE);
  assign event_count = r_event_count;

endmodule

// File: tb/tb_emergency_preempt_ctrl.sv
// Scenario bench for emergency_preempt_ctrl: expected results are queued at stimulus time
// and popped when the corresponding DUT behaviour is observed.
module tb_emergency_preempt_ctrl;

  logic       clk;
  logic       reset;
  logic       siren_raw;
  logic       manual_override;
  logic       cfg_enable;
  logic       emergency;
  logic       all_red;
  logic       busy;
  logic [7:0] event_count;

  logic       reset2;
  logic       man2;
  logic       siren2;
  logic       cfg2;
  logic       e2;
  logic       a2;
  logic       b2;
  logic [1:0] cnt2;

  typedef struct {
    string       name;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;
  int  exp_cnt = 0;

  emergency_preempt_ctrl dut (
    .clk(clk), .reset(reset), .siren_raw(siren_raw), .manual_override(manual_override),
    .cfg_enable(cfg_enable), .emergency(emergency), .all_red(all_red), .busy(busy),
    .event_count(event_count)
  );

  emergency_preempt_ctrl #(.MIN_HOLD(2), .CLEAR_CYCLES(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .siren_raw(siren2), .manual_override(man2),
    .cfg_enable(cfg2), .emergency(e2), .all_red(a2), .busy(b2), .event_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 500) begin
      step();
      k++;
    end
    if (busy !== 1'b0) $display("FAIL idle_timeout: busy=%b required 0", busy);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [31:0] obs;
    reset = 1'b1; siren_raw = 1'b1; manual_override = 1'b1; cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{"reset_outputs", 32'd0});
      step();
      e = sb.pop_front();
      obs = 32'({emergency, all_red, busy, event_count});
      if (obs !== e.val) $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val);
      else n_pass++;
      n_total++;
    end
    reset = 1'b0;
    sb.push_back('{"reset_release_manual_latency", 32'd1});
    step();
    e = sb.pop_front();
    obs = 32'(emergency);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    exp_cnt = 1;
    manual_override = 1'b0; siren_raw = 1'b0;
    sb.push_back('{"count_after_reset_entry", 32'(exp_cnt)});
    wait_idle();
    e = sb.pop_front();
    obs = 32'(event_count);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_siren_steady();
    sb_t e;
    logic [31:0] obs;
    int k = 0;
    int n = 0;
    sb.push_back('{"siren_latency", 32'd10});
    siren_raw = 1'b1;
    do begin
      step();
      k++;
    end while (emergency !== 1'b1 && k < 100);
    e = sb.pop_front();
    obs = (emergency === 1'b1) ? 32'(k) : 32'd999;
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    exp_cnt++;
    sb.push_back('{"siren_count", 32'(exp_cnt)});
    e = sb.pop_front();
    obs = 32'(event_count);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    sb.push_back('{"siren_hold_cycles", 32'd50});
    repeat (50) begin
      step();
      if (emergency === 1'b1) n++;
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    siren_raw = 1'b0;
    wait_idle();
  endtask

  task automatic test_siren_short();
    sb_t e;
    logic [31:0] obs;
    int n = 0;
    sb.push_back('{"short_siren_emergency_cycles", 32'd0});
    sb.push_back('{"short_siren_count", 32'(exp_cnt)});
    siren_raw = 1'b1;
    repeat (5) step();
    siren_raw = 1'b0;
    repeat (30) begin
      step();
      if (emergency !== 1'b0) n++;
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    e = sb.pop_front();
    obs = 32'(event_count);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_siren_glitch();
    sb_t e;
    logic [31:0] obs;
    int first = 0;
    // Raw low for the edge that makes siren_s low while qualify count is 6.
    sb.push_back('{"glitch_restart_latency", 32'd17});
    siren_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (emergency === 1'b1 && first == 0) first = k;
      if (k == 6)  siren_raw = 1'b0;
      if (k == 7)  siren_raw = 1'b1;
      if (k == 20) siren_raw = 1'b0;
    end
    e = sb.pop_front();
    obs = 32'(first);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    exp_cnt++;
    sb.push_back('{"glitch_count", 32'(exp_cnt)});
    wait_idle();
    e = sb.pop_front();
    obs = 32'(event_count);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_hold_clear();
    sb_t e;
    logic [31:0] obs;
    int k = 0;
    int n = 0;
    sb.push_back('{"hold_emergency_cycles", 32'd32});
    sb.push_back('{"hold_all_red_cycles", 32'd4});
    sb.push_back('{"hold_busy_after", 32'd0});
    siren_raw = 1'b1;
    while (emergency !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    while (emergency === 1'b1 && n < 200) begin
      n++;
      if (n == 3) siren_raw = 1'b0;
      step();
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    n = 0;
    while (all_red === 1'b1 && n < 200) begin
      n++;
      step();
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    e = sb.pop_front();
    obs = 32'(busy);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    exp_cnt++;
    sb.push_back('{"hold_count", 32'(exp_cnt)});
    e = sb.pop_front();
    obs = 32'(event_count);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_manual();
    sb_t e;
    logic [31:0] obs;
    int n = 0;
    sb.push_back('{"manual_latency", 32'd1});
    sb.push_back('{"manual_emergency_cycles", 32'd32});
    sb.push_back('{"manual_all_red_cycles", 32'd4});
    manual_override = 1'b1;
    step();
    manual_override = 1'b0;
    e = sb.pop_front();
    obs = 32'(emergency);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    while (emergency === 1'b1 && n < 200) begin
      n++;
      step();
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    n = 0;
    while (all_red === 1'b1 && n < 200) begin
      n++;
      step();
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    exp_cnt++;
    // Disabled: the same pulse must be ignored entirely.
    sb.push_back('{"disabled_busy_cycles", 32'd0});
    sb.push_back('{"disabled_count", 32'(exp_cnt)});
    cfg_enable = 1'b0;
    manual_override = 1'b1;
    step();
    manual_override = 1'b0;
    n = 0;
    repeat (40) begin
      if (busy !== 1'b0) n++;
      step();
    end
    e = sb.pop_front();
    obs = 32'(n);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    e = sb.pop_front();
    obs = 32'(event_count);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    cfg_enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    sb_t e;
    logic [31:0] obs;
    sb.push_back('{"pre_reset_emergency", 32'd1});
    manual_override = 1'b1;
    step();
    manual_override = 1'b0;
    repeat (10) step();
    e = sb.pop_front();
    obs = 32'(emergency);
    if (obs !== e.val) $display("FAIL %s: observed %0d required %0d", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    exp_cnt = 0;
    sb.push_back('{"mid_reset_outputs", 32'd0});
    reset = 1'b1;
    #1;
    e = sb.pop_front();
    obs = 32'({emergency, all_red, busy, event_count});
    if (obs !== e.val) $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val);
    else n_pass++;
    n_total++;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    sb_t e;
    logic [31:0] obs;
    reset2 = 1'b0;
    step();
    for (int p = 1; p <= 5; p++) begin
      sb.push_back('{"sat_count", 32'((p > 3) ? 3 : p)});
      man2 = 1'b1;
      step();
      man2 = 1'b0;
      repeat (8) step();
      e = sb.pop_front();
      obs = 32'(cnt2);
      if (obs !== e.val) $display("FAIL %s: observed %0d required %0d (pulse %0d)", e.name, obs, e.val, p);
      else n_pass++;
      n_total++;
    end
    sb.push_back('{"sat_idle_outputs", 32'd0});
    e = sb.pop_front();
    obs = 32'({e2, a2, b2});
    if (obs !== e.val) $display("FAIL %s: observed %0h required %0h", e.name, obs, e.val);
    else n_pass++;
    n_total++;
  endtask

  initial begin
    reset = 1'b1; siren_raw = 1'b0; manual_override = 1'b0; cfg_enable = 1'b1;
    reset2 = 1'b1; man2 = 1'b0; siren2 = 1'b0; cfg2 = 1'b1;
    test_reset();
    test_siren_steady();
    test_siren_short();
    test_siren_glitch();
    test_hold_clear();
    test_manual();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
